// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read-side and serial-line signals of the UART transmitter.
interface fifo_uart_tx_if #(parameter int DATA_W = 8);
  logic              empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              r_en;
  logic              tx;
  logic              busy;
  logic              tx_done;
  modport master (output empty, fifo_dout, input r_en, tx, busy, tx_done);
  modport slave  (input empty, fifo_dout, output r_en, tx, busy, tx_done);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an async FIFO read port word by word into 8N1-style UART frames.
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input logic r_clk,
  input logic r_reset,
  fifo_uart_tx_if.slave bus
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, READ, LATCH, START, DATA, STOP} state_t;
  state_t            state;
  logic [BW-1:0]     baud;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nx;
  logic              r_en;
  logic              tx;
  logic              busy;
  logic              tx_done;
  logic              baud_last;
  logic              bit_last;
  assign shift_nx  = shift >> 1;
  assign baud_last = baud == BW'(CLKS_PER_BIT - 1);
  assign bit_last  = bit_cnt == CW'(DATA_W - 1);
  // The start bit begins in LATCH (tx dropped at the end of READ), so LATCH is
  // baud slot 0 and START covers the remaining slots; this keeps the idle gap
  // between back-to-back frames at two cycles (IDLE, READ).
  always_ff @(posedge r_clk or posedge r_reset)
    if (r_reset) begin
      state   <= IDLE;
      r_en    <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      r_en    <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: if (!bus.empty) begin
          r_en  <= 1'b1;
          busy  <= 1'b1;
          state <= READ;
        end
        READ: begin
          tx    <= 1'b0;
          baud  <= '0;
          state <= LATCH;
        end
        LATCH: begin
          shift <= bus.fifo_dout;
          baud  <= BW'(1);
          state <= baud_last ? DATA : START;
          if (baud_last) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= bus.fifo_dout[0];
          end
        end
        START: begin
          baud <= baud_last ? '0 : baud + BW'(1);
          if (baud_last) begin
            bit_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end
        end
        DATA: begin
          baud <= baud_last ? '0 : baud + BW'(1);
          if (baud_last) begin
            shift   <= shift_nx;
            bit_cnt <= bit_cnt + CW'(1);
            tx      <= bit_last ? 1'b1 : shift_nx[0];
            state   <= bit_last ? STOP : DATA;
          end
        end
        STOP: begin
          baud    <= baud_last ? '0 : baud + BW'(1);
          tx_done <= baud == BW'(CLKS_PER_BIT - 2);
          if (baud_last) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  assign bus.r_en    = r_en;
  assign bus.tx      = tx;
  assign bus.busy    = busy;
  assign bus.tx_done = tx_done;
endmodule
